// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_pkg
//  Description : Shared types, funct3 encodings and decode helpers for the
//                load/store sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    // Sequencer states: one op in flight, RESP is the single completion cycle
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_e;

    // Fault cause reported alongside rsp_err
    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'b00,
        CAUSE_MISALIGN = 2'b01,
        CAUSE_TIMEOUT  = 2'b10,
        CAUSE_ILLEGAL  = 2'b11
    } cause_e;

    // funct3 encodings for loads and stores (stores use B/H/W only)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Half accesses need an even address, word accesses a multiple of four
    function automatic logic is_misaligned(input logic [2:0] f3,
                                           input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        case (f3)
            F3_H, F3_HU: mis = addr_lo[0];
            F3_W:        mis = (addr_lo != 2'b00);
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Stores only have B/H/W; loads additionally have BU/HU
    function automatic logic is_illegal_f3(input logic       we,
                                           input logic [2:0] f3);
        logic ill;
        if (we) begin
            ill = (f3 != F3_B) && (f3 != F3_H) && (f3 != F3_W);
        end else begin
            ill = (f3 != F3_B) && (f3 != F3_H) && (f3 != F3_W) &&
                  (f3 != F3_BU) && (f3 != F3_HU);
        end
        return ill;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_align
//  Description : Combinational byte-lane logic: byte enables, lane-replicated
//                store data and extracted/extended load data.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      i_f3,
    input  logic [1:0]      i_addr_lo,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [XLEN-1:0] i_rdata,
    output logic [3:0]      o_be,
    output logic [XLEN-1:0] o_wdata,
    output logic [XLEN-1:0] o_rdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_unsigned;

    // Pick the addressed byte/half out of the returned word
    assign w_byte     = 8'(i_rdata >> {i_addr_lo, 3'b000});
    assign w_half     = 16'(i_rdata >> {i_addr_lo[1], 4'b0000});
    assign w_unsigned = i_f3[2];

    // Size decode from f3[1:0]; f3[2] selects zero-extension for loads
    always_comb begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
        o_rdata = i_rdata;
        case (i_f3[1:0])
            2'b00: begin
                o_be    = 4'b0001 << i_addr_lo;
                o_wdata = {(XLEN/8){i_wdata[7:0]}};
                o_rdata = {{(XLEN-8){w_unsigned ? 1'b0 : w_byte[7]}}, w_byte};
            end
            2'b01: begin
                o_be    = 4'b0011 << {i_addr_lo[1], 1'b0};
                o_wdata = {(XLEN/16){i_wdata[15:0]}};
                o_rdata = {{(XLEN-16){w_unsigned ? 1'b0 : w_half[15]}}, w_half};
            end
            default: begin
                o_be    = 4'b1111;
                o_wdata = i_wdata;
                o_rdata = i_rdata;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_sequencer
//  Description : Multi-cycle load/store sequencer between execute and the
//                data-memory bus: fault checks, bus handshake, load
//                extension, grant/response timeout and pipeline stall.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_sequencer
    import lsu_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int MAX_WAIT = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_f3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err,
    output logic [1:0]      rsp_cause,
    output logic            stall,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [3:0]      mem_be,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata
);

    // Counter holds the number of REQ/WAIT cycles already spent; the
    // current cycle is the limit cycle when it equals MAX_WAIT-2.
    localparam int unsigned    CNT_W     = $clog2(MAX_WAIT) + 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_WAIT - 2);

    state_e            state_q, state_d;
    cause_e            cause_q, cause_d;
    logic              we_q, we_d;
    logic [2:0]        f3_q, f3_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [3:0]        w_be;
    logic [XLEN-1:0]   w_wdata_rep;
    logic [XLEN-1:0]   w_rdata_ext;
    logic              w_limit;

    assign w_limit = (cnt_q >= CNT_LIMIT);

    lsu_align #(
        .XLEN (XLEN)
    ) u_align (
        .i_f3      (f3_q),
        .i_addr_lo (addr_q[1:0]),
        .i_wdata   (wdata_q),
        .i_rdata   (mem_rdata),
        .o_be      (w_be),
        .o_wdata   (w_wdata_rep),
        .o_rdata   (w_rdata_ext)
    );

    // State and latched-op registers; reset clears everything immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cause_q <= CAUSE_NONE;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, latch updates and Moore-style outputs
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        we_d    = we_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;

        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_rdata = '0;
        rsp_err   = 1'b0;
        rsp_cause = 2'b00;
        stall     = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_be    = 4'b0000;
        mem_wdata = '0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                stall     = req_valid;
                if (req_valid) begin
                    we_d    = req_we;
                    f3_d    = req_f3;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rdata_d = '0;
                    cnt_d   = '0;
                    // Illegal f3 outranks misalignment; faults skip the bus
                    if (is_illegal_f3(req_we, req_f3)) begin
                        cause_d = CAUSE_ILLEGAL;
                        state_d = RESP;
                    end else if (is_misaligned(req_f3, req_addr[1:0])) begin
                        cause_d = CAUSE_MISALIGN;
                        state_d = RESP;
                    end else begin
                        cause_d = CAUSE_NONE;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                stall     = 1'b1;
                mem_req   = 1'b1;
                mem_we    = we_q;
                mem_addr  = {addr_q[XLEN-1:2], 2'b00};
                mem_be    = w_be;
                mem_wdata = w_wdata_rep;
                cnt_d     = cnt_q + CNT_W'(1);
                // A grant on the limit cycle still counts as progress
                if (mem_gnt) begin
                    state_d = WAIT;
                end else if (w_limit) begin
                    cause_d = CAUSE_TIMEOUT;
                    state_d = RESP;
                end
            end
            WAIT: begin
                stall = 1'b1;
                cnt_d = cnt_q + CNT_W'(1);
                if (mem_rvalid) begin
                    rdata_d = we_q ? '0 : w_rdata_ext;
                    state_d = RESP;
                end else if (w_limit) begin
                    cause_d = CAUSE_TIMEOUT;
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_rdata = rdata_q;
                rsp_err   = (cause_q != CAUSE_NONE);
                rsp_cause = cause_q;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lsu_sequencer
//  Description : Randomized self-checking bench for lsu_sequencer with a
//                transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_sequencer;

    localparam int XLEN     = 32;
    localparam int MAX_WAIT = 16;

    logic            clk;
    logic            rst_n;
    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [2:0]      req_f3;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic            rsp_valid;
    logic [XLEN-1:0] rsp_rdata;
    logic            rsp_err;
    logic [1:0]      rsp_cause;
    logic            stall;
    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [3:0]      mem_be;
    logic [XLEN-1:0] mem_wdata;
    logic            mem_gnt;
    logic            mem_rvalid;
    logic [XLEN-1:0] mem_rdata;

    int n_checks = 0;
    int n_errors = 0;

    lsu_sequencer #(
        .XLEN     (XLEN),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_f3     (req_f3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_cause  (rsp_cause),
        .stall      (stall),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Runs one op. Bus grants on the (g+1)th cycle after accept and answers
    // r cycles after the grant, whether or not the sequencer still waits.
    task automatic run_op(input bit we, input bit [2:0] f3, input bit [31:0] addr,
                          input bit [31:0] wdata, input bit [31:0] rword,
                          input int g, input int r);
        int          size;
        int          lim;
        int          exp_rsp;
        int          last_req;
        int          end_cyc;
        int          ofs;
        int          t;
        bit          illegal;
        bit          fault;
        bit          tmo;
        logic [1:0]  exp_cause;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
        logic [31:0] exp_rd;
        logic [31:0] v;

        size    = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        ofs     = int'(addr % 4);
        illegal = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 >= 3'd6);
        lim     = MAX_WAIT - 1;
        tmo     = 1'b0;
        fault   = 1'b0;
        exp_cause = 2'b00;

        // Outcome and timing from the transaction rules
        if (illegal) begin
            fault = 1'b1; exp_cause = 2'b11;
        end else if ((addr % size) != 0) begin
            fault = 1'b1; exp_cause = 2'b01;
        end
        if (fault) begin
            exp_rsp  = 1;
            last_req = 0;
        end else if (g + 1 > lim) begin
            tmo = 1'b1; last_req = lim; exp_rsp = lim + 1;
        end else begin
            last_req = g + 1;
            // Waiting cycles without rvalid are g+2 .. g+r; any at/after lim times out
            if (r >= 2 && g + r >= lim) begin
                tmo = 1'b1;
                t   = (g + 2 > lim) ? g + 2 : lim;
                exp_rsp = t + 1;
            end else begin
                exp_rsp = g + r + 2;
            end
        end
        if (tmo) exp_cause = 2'b10;

        exp_be = (size == 1) ? 4'(1 << ofs) : (size == 2) ? 4'(3 << ofs) : 4'hF;
        exp_wd = (size == 1) ? wdata[7:0] * 32'h0101_0101 :
                 (size == 2) ? wdata[15:0] * 32'h0001_0001 : wdata;
        exp_rd = 32'h0;
        if (!fault && !tmo && !we) begin
            v = rword >> (8 * ofs);
            if (size == 1) begin
                v = v & 32'hFF;
                if (f3 == 3'd0 && v[7]) v = v | 32'hFFFF_FF00;
            end else if (size == 2) begin
                v = v & 32'hFFFF;
                if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
            end
            exp_rd = v;
        end

        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_f3 = f3; req_addr = addr; req_wdata = wdata;
        mem_rdata = rword; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        #1;
        chk("idle_ready", req_ready, 1);
        chk("idle_stall", stall, 1);

        end_cyc = ((exp_rsp > g + 1 + r) ? exp_rsp : g + 1 + r) + 1;
        for (int c = 1; c <= end_cyc; c++) begin
            @(posedge clk); #1;
            mem_gnt    = (c == g + 1);
            mem_rvalid = (c == g + 1 + r);
            #1;
            chk("rsp_valid", rsp_valid, (c == exp_rsp));
            chk("mem_req", mem_req, (c <= last_req));
            chk("stall", stall, (c < exp_rsp));
            chk("req_ready", req_ready, (c > exp_rsp));
            if (c <= last_req) begin
                chk("mem_addr", mem_addr, {addr[31:2], 2'b00});
                chk("mem_be", 32'(mem_be), 32'(exp_be));
                chk("mem_we", mem_we, we);
                if (we) chk("mem_wdata", mem_wdata, exp_wd);
            end
            if (c == exp_rsp) begin
                chk("rsp_rdata", rsp_rdata, exp_rd);
                chk("rsp_err", rsp_err, (exp_cause != 2'b00));
                chk("rsp_cause", 32'(rsp_cause), 32'(exp_cause));
                req_valid = 1'b0;
            end
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
    endtask

    // Starts an LW, pulses reset in REQ (in_wait=0) or WAIT (in_wait=1)
    task automatic reset_mid(input bit in_wait);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_f3 = 3'd2; req_addr = 32'h40; req_wdata = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        @(posedge clk); #1;
        mem_gnt = in_wait;
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        @(posedge clk); #2;
        chk("pre_rst_mem_req", mem_req, !in_wait);
        chk("pre_rst_stall", stall, 1);
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_stall", stall, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_req_ready", req_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bit          we;
        bit [2:0]    f3;
        bit [31:0]   addr;
        int          g;
        int          r;

        rst_n = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_f3 = '0; req_addr = '0;
        req_wdata = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("reset_ready", req_ready, 1);
        chk("reset_mem_req", mem_req, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_stall", stall, 0);
        chk("reset_rdata", rsp_rdata, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // Directed cases
        run_op(0, 3'd2, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 1);
        run_op(0, 3'd0, 32'h203, 32'h0, 32'h8011_2233, 0, 1);
        run_op(0, 3'd4, 32'h203, 32'h0, 32'h8011_2233, 0, 1);
        run_op(0, 3'd5, 32'h202, 32'h0, 32'h8011_2233, 1, 2);
        run_op(1, 3'd1, 32'h006, 32'h0000_ABCD, 32'h1234_5678, 0, 2);
        run_op(0, 3'd2, 32'h102, 32'h0, 32'h0, 0, 1);
        run_op(1, 3'd3, 32'h100, 32'h0, 32'h0, 0, 1);
        run_op(0, 3'd3, 32'h101, 32'h0, 32'h0, 0, 1);
        run_op(0, 3'd2, 32'h300, 32'h0, 32'h0, 40, 1);
        run_op(0, 3'd2, 32'h304, 32'h0, 32'hCAFE_F00D, 14, 1);
        run_op(0, 3'd2, 32'h308, 32'h0, 32'hCAFE_F00D, 3, 12);
        run_op(0, 3'd2, 32'h30C, 32'h0, 32'hCAFE_F00D, 3, 11);
        reset_mid(1'b1);
        run_op(0, 3'd2, 32'h400, 32'h0, 32'h1357_9BDF, 5, 8);
        reset_mid(1'b0);
        run_op(1, 3'd0, 32'h401, 32'h0000_00A5, 32'h0, 0, 1);

        // Randomized ops
        for (int i = 0; i < 200; i++) begin
            we   = 1'($urandom_range(0, 1));
            f3   = 3'($urandom_range(0, 7));
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
            g = ($urandom_range(0, 9) < 7) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 18));
            r = ($urandom_range(0, 9) < 7) ? int'($urandom_range(1, 3)) : int'($urandom_range(1, 16));
            run_op(we, f3, addr, $urandom, $urandom, g, r);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
